mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch, data load/store) sharing one memory port.
// Data has priority; a waiting fetch is forced through after MAX_DATA_STREAK data grants.
//
// state  | meaning
// IDLE   | no transaction; evaluate requests on each edge
// ACCESS | memory port driven for MEM_LATENCY cycles
// RESP   | one-cycle ack to the granted master
module mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_re,
  output logic                  m_we,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT_LAST   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [3:0]  streak_q;
  logic [3:0]  streak_d;
  logic        fetch_q;
  logic        grant_fetch;
  logic        grant_data;
  logic        misaligned;

  // Misaligned data accesses still count as data grants for the streak.
  always_comb begin
    grant_fetch = i_req && (!d_req || (streak_q == STREAK_MAX));
    grant_data  = d_req && !grant_fetch;
    misaligned  = (d_addr[1:0] != 2'b00);
    streak_d    = streak_q;
    if (grant_fetch) begin
      streak_d = '0;
    end else if (grant_data) begin
      if (!i_req)                        streak_d = '0;
      else if (streak_q == STREAK_MAX)   streak_d = STREAK_MAX;
      else                               streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      streak_q <= '0;
      fetch_q  <= 1'b0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      busy     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_fetch || grant_data) begin
            streak_q <= streak_d;
            fetch_q  <= grant_fetch;
            busy     <= 1'b1;
            cnt_q    <= LAT_LAST;
            if (grant_fetch) begin
              m_addr  <= i_addr;
              m_re    <= 1'b1;
              state_q <= ACCESS;
            end else begin
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              if (misaligned) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                state_q <= RESP;
              end else begin
                m_re    <= !d_we;
                m_we    <= d_we;
                state_q <= ACCESS;
              end
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 3'd0) begin
            if (m_re) begin
              if (fetch_q) i_rdata <= m_rdata;
              else         d_rdata <= m_rdata;
            end
            m_re    <= 1'b0;
            m_we    <= 1'b0;
            i_ack   <= fetch_q;
            d_ack   <= !fetch_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
          d_err   <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
